// File: rtl/pwr_clock_gate_ctrl_if.sv
// Boundary signals between the requesters / gated domain and the clock-gate controller.
// The controller uses the slave modport; requesters and status readers use master.
interface pwr_clock_gate_ctrl_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic               busy;
  logic               force_on;
  logic               gate_en;
  logic               ready;
  logic [NUM_REQ-1:0] ack;
  logic               gated;
  logic [15:0]        gate_count;

  modport master (
    output req,
    output busy,
    output force_on,
    input  gate_en,
    input  ready,
    input  ack,
    input  gated,
    input  gate_count
  );

  modport slave (
    input  req,
    input  busy,
    input  force_on,
    output gate_en,
    output ready,
    output ack,
    output gated,
    output gate_count
  );
endinterface

// File: rtl/pwr_clock_gate_ctrl.sv
// Idle-timeout controller for a latch-based clock gate: gates after IDLE_CYCLES quiet
// cycles, re-enables on activity and holds ready low for WAKE_CYCLES while the domain settles.
module pwr_clock_gate_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 8,
  // Width of the saturating gating-event counter; narrower values saturate early and
  // are zero-extended onto the 16-bit gate_count port.
  parameter int GCNT_W      = 16
) (
  input logic                  clk,
  input logic                  rst,
  pwr_clock_gate_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_IDLE   = 2'd1,
    ST_GATED  = 2'd2,
    ST_WAKE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [GCNT_W-1:0] GCNT_ONE  = GCNT_W'(1);
  localparam logic [GCNT_W-1:0] GCNT_MAX  = {GCNT_W{1'b1}};

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [GCNT_W-1:0] gcnt_reg, gcnt_next;
  logic              activity;

  assign activity = (|bus.req) | bus.busy | bus.force_on;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_ACTIVE;
      cnt_reg   <= '0;
      gcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      gcnt_reg  <= gcnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    gcnt_next  = gcnt_reg;
    case (state_reg)
      ST_ACTIVE: begin
        cnt_next = '0;
        if (!activity) begin
          state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (activity) begin
          state_next = ST_ACTIVE;
          cnt_next   = '0;
        end else if (cnt_reg == IDLE_LAST) begin
          state_next = ST_GATED;
          cnt_next   = '0;
          if (gcnt_reg != GCNT_MAX) begin
            gcnt_next = gcnt_reg + GCNT_ONE;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      ST_GATED: begin
        // busy is part of activity, so even a stray busy from the domain wakes it.
        if (activity) begin
          state_next = ST_WAKE;
          cnt_next   = '0;
        end
      end
      ST_WAKE: begin
        // A wake always runs to completion, regardless of activity.
        if (cnt_reg == WAKE_LAST) begin
          state_next = ST_ACTIVE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = ST_ACTIVE;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs decode only from registered state so gate_en never glitches.
  assign bus.gate_en    = (state_reg != ST_GATED);
  assign bus.ready      = (state_reg == ST_ACTIVE) || (state_reg == ST_IDLE);
  assign bus.gated      = (state_reg == ST_GATED);
  assign bus.gate_count = 16'(gcnt_reg);

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
      assign bus.ack[gi] = bus.req[gi] & bus.ready;
    end
  endgenerate

endmodule

// File: tb/tb_pwr_clock_gate_ctrl.sv
// Directed bench for pwr_clock_gate_ctrl: default-parameter instance plus a short-timeout
// instance with a 3-bit event counter for exercising saturation.
module tb_pwr_clock_gate_ctrl;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  pwr_clock_gate_ctrl_if #(.NUM_REQ(4)) bus ();
  pwr_clock_gate_ctrl_if #(.NUM_REQ(4)) sat_bus ();

  pwr_clock_gate_ctrl #(
    .NUM_REQ(4), .IDLE_CYCLES(16), .WAKE_CYCLES(2), .CNT_W(8), .GCNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  pwr_clock_gate_ctrl #(
    .NUM_REQ(4), .IDLE_CYCLES(1), .WAKE_CYCLES(1), .CNT_W(4), .GCNT_W(3)
  ) dut_sat (
    .clk(clk),
    .rst(rst),
    .bus(sat_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0; bus.busy = 1'b0; bus.force_on = 1'b0;
    sat_bus.req = '0; sat_bus.busy = 1'b0; sat_bus.force_on = 1'b0;
    steps(2);
    rst = 1'b0;
    tests_run++;
    if (bus.gate_en !== 1'b1 || bus.ready !== 1'b1 || bus.gated !== 1'b0 ||
        bus.gate_count !== 16'd0 || bus.ack !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_state: gate_en=%b ready=%b gated=%b count=%0d ack=%b, want 1 1 0 0 0000",
               bus.gate_en, bus.ready, bus.gated, bus.gate_count, bus.ack);
    end
    $display("[TB] reset: gate_en=%b ready=%b gated=%b count=%0d",
             bus.gate_en, bus.ready, bus.gated, bus.gate_count);
  endtask

  task automatic test_idle_timeout();
    for (int e = 1; e <= 16; e++) begin
      step();
      tests_run++;
      if (bus.gate_en !== 1'b1) begin
        tests_failed++;
        $display("FAIL idle_gate_en_edge%0d: gate_en=%b, want 1", e, bus.gate_en);
      end
    end
    step();
    tests_run++;
    if (bus.gate_en !== 1'b0 || bus.gated !== 1'b1 || bus.gate_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL idle_gated_edge17: gate_en=%b gated=%b count=%0d, want 0 1 1",
               bus.gate_en, bus.gated, bus.gate_count);
    end
    $display("[TB] idle timeout: gate_en=%b gated=%b count=%0d", bus.gate_en, bus.gated, bus.gate_count);
  endtask

  task automatic test_wake_pulse();
    bus.req = 4'b0100;
    step();
    bus.req = 4'b0000;
    tests_run++;
    if (bus.gate_en !== 1'b1 || bus.ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL wake_w0: gate_en=%b ready=%b, want 1 0", bus.gate_en, bus.ready);
    end
    step();
    tests_run++;
    if (bus.ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL wake_w1: ready=%b, want 0", bus.ready);
    end
    step();
    tests_run++;
    if (bus.ready !== 1'b1 || bus.ack !== 4'b0000) begin
      tests_failed++;
      $display("FAIL wake_w2: ready=%b ack=%b, want 1 0000", bus.ready, bus.ack);
    end
    steps(16);
    tests_run++;
    if (bus.gated !== 1'b0) begin
      tests_failed++;
      $display("FAIL wake_regate_early: gated=%b, want 0", bus.gated);
    end
    step();
    tests_run++;
    if (bus.gated !== 1'b1 || bus.gate_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL wake_regate: gated=%b count=%0d, want 1 2", bus.gated, bus.gate_count);
    end
    $display("[TB] wake pulse: gated=%b count=%0d", bus.gated, bus.gate_count);
  endtask

  task automatic test_ack_hold();
    bus.req = 4'b0010;
    step();
    tests_run++;
    if (bus.ack !== 4'b0000) begin
      tests_failed++;
      $display("FAIL ack_w0: ack=%b, want 0000", bus.ack);
    end
    step();
    tests_run++;
    if (bus.ack !== 4'b0000) begin
      tests_failed++;
      $display("FAIL ack_w1: ack=%b, want 0000", bus.ack);
    end
    step();
    tests_run++;
    if (bus.ack !== 4'b0010) begin
      tests_failed++;
      $display("FAIL ack_w2: ack=%b, want 0010", bus.ack);
    end
    bus.req = 4'b1010;
    #1;
    tests_run++;
    if (bus.ack !== 4'b1010) begin
      tests_failed++;
      $display("FAIL ack_active: ack=%b, want 1010", bus.ack);
    end
    bus.req = 4'b0000;
    steps(17);
    tests_run++;
    if (bus.gated !== 1'b1 || bus.gate_count !== 16'd3) begin
      tests_failed++;
      $display("FAIL ack_regate: gated=%b count=%0d, want 1 3", bus.gated, bus.gate_count);
    end
    $display("[TB] ack hold: gated=%b count=%0d", bus.gated, bus.gate_count);
  endtask

  task automatic test_busy_restart();
    bus.req = 4'b0001;
    step();
    bus.req = 4'b0000;
    steps(2);
    steps(11);
    bus.busy = 1'b1;
    step();
    bus.busy = 1'b0;
    tests_run++;
    if (bus.ready !== 1'b1 || bus.gated !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_active: ready=%b gated=%b, want 1 0", bus.ready, bus.gated);
    end
    steps(6);
    tests_run++;
    if (bus.gated !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_no_early_gate: gated=%b, want 0", bus.gated);
    end
    steps(10);
    tests_run++;
    if (bus.gated !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_gate_edge16: gated=%b, want 0", bus.gated);
    end
    step();
    tests_run++;
    if (bus.gated !== 1'b1 || bus.gate_count !== 16'd4) begin
      tests_failed++;
      $display("FAIL busy_gate_edge17: gated=%b count=%0d, want 1 4", bus.gated, bus.gate_count);
    end
    $display("[TB] busy restart: gated=%b count=%0d", bus.gated, bus.gate_count);
  endtask

  task automatic test_force_on();
    int bad;
    bus.force_on = 1'b1;
    steps(3);
    tests_run++;
    if (bus.ready !== 1'b1 || bus.gate_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL force_wake: ready=%b gate_en=%b, want 1 1", bus.ready, bus.gate_en);
    end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      tests_run++;
      if (bus.gate_en !== 1'b1 || bus.ready !== 1'b1) begin
        tests_failed++;
        bad++;
        if (bad <= 3)
          $display("FAIL force_hold_cycle%0d: gate_en=%b ready=%b, want 1 1", i, bus.gate_en, bus.ready);
      end
    end
    tests_run++;
    if (bus.gate_count !== 16'd4) begin
      tests_failed++;
      $display("FAIL force_count: count=%0d, want 4", bus.gate_count);
    end
    bus.force_on = 1'b0;
    steps(17);
    tests_run++;
    if (bus.gated !== 1'b1 || bus.gate_count !== 16'd5) begin
      tests_failed++;
      $display("FAIL force_release_gate: gated=%b count=%0d, want 1 5", bus.gated, bus.gate_count);
    end
    $display("[TB] force_on: gated=%b count=%0d", bus.gated, bus.gate_count);
  endtask

  task automatic test_reset_in_wake();
    bus.req = 4'b0001;
    steps(2);
    tests_run++;
    if (bus.ready !== 1'b0 || bus.gate_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstwake_in_wake: ready=%b gate_en=%b, want 0 1", bus.ready, bus.gate_en);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req = 4'b0000;
    tests_run++;
    if (bus.ready !== 1'b1 || bus.gate_en !== 1'b1 || bus.gate_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL rstwake_after: ready=%b gate_en=%b count=%0d, want 1 1 0",
               bus.ready, bus.gate_en, bus.gate_count);
    end
    $display("[TB] reset in wake: ready=%b gate_en=%b count=%0d", bus.ready, bus.gate_en, bus.gate_count);
  endtask

  task automatic test_saturation();
    int exp_cnt;
    rst = 1'b1;
    step();
    rst = 1'b0;
    steps(2);
    tests_run++;
    if (sat_bus.gated !== 1'b1 || sat_bus.gate_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL sat_first_gate: gated=%b count=%0d, want 1 1", sat_bus.gated, sat_bus.gate_count);
    end
    for (int n = 2; n <= 10; n++) begin
      sat_bus.req = 4'b1000;
      step();
      sat_bus.req = 4'b0000;
      step();
      steps(2);
      exp_cnt = (n > 7) ? 7 : n;
      tests_run++;
      if (sat_bus.gated !== 1'b1 || sat_bus.gate_count !== 16'(exp_cnt)) begin
        tests_failed++;
        $display("FAIL sat_event%0d: gated=%b count=%0d, want 1 %0d",
                 n, sat_bus.gated, sat_bus.gate_count, exp_cnt);
      end
      $display("[TB] saturation event %0d: count=%0d", n, sat_bus.gate_count);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    test_reset();
    test_idle_timeout();
    test_wake_pulse();
    test_ack_hold();
    test_busy_restart();
    test_force_on();
    test_reset_in_wake();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
